// File: rtl/if_id_fetch.sv
// if_id_fetch: fetch sequencer with one outstanding imem request, one-entry skid buffer
// and the IF/ID pipeline register (flush > stall > load).
module if_id_fetch #(
   parameter logic [31:0] RESET_PC = 32'd100,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] pc_in,
   input  logic        stall,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        pc_en,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_instr
);
   typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;
   state_t      state;
   logic [31:0] req_pc, skid_pc, skid_instr, src_pc, src_instr;
   logic        load;

   // A new request may overlap only with consumption of the previous response.
   always_comb begin
      imem_req  = resetn & !stall & !flush & ((state == IDLE) | ((state == WAIT) & imem_rvalid));
      load      = !flush & !stall & (((state == WAIT) & imem_rvalid) | (state == HOLD));
      src_pc    = (state == HOLD) ? skid_pc : req_pc;
      src_instr = (state == HOLD) ? skid_instr : imem_rdata;
   end

   assign pc_en     = imem_req;
   assign imem_addr = pc_in;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= IDLE;
         req_pc      <= RESET_PC;
         skid_pc     <= RESET_PC;
         skid_instr  <= NOP;
         if_id_valid <= 1'b0;
         if_id_pc    <= RESET_PC;
         if_id_pc4   <= RESET_PC + 32'd4;
         if_id_instr <= NOP;
      end else begin
         if (flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP;
         end else if (!stall) begin
            if_id_valid <= load;
            if_id_instr <= load ? src_instr : NOP;
            if (load) begin
               if_id_pc  <= src_pc;
               if_id_pc4 <= src_pc + 32'd4;
            end
         end
         if (imem_req) req_pc <= pc_in;
         case (state)
            IDLE:    if (imem_req) state <= WAIT;
            WAIT: begin
               if (flush) state <= imem_rvalid ? IDLE : DRAIN;
               else if (imem_rvalid & stall) begin
                  state      <= HOLD;
                  skid_pc    <= req_pc;
                  skid_instr <= imem_rdata;
               end
            end
            HOLD:    if (flush | !stall) state <= IDLE;
            DRAIN:   if (imem_rvalid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_if_id_fetch.sv
// tb_if_id_fetch: directed scenarios plus a randomized run against a queue-based
// reference model of the fetch stage with a variable-latency memory.
module tb_if_id_fetch;
   logic        clock, resetn, stall, flush, imem_req, imem_rvalid, pc_en, if_id_valid;
   logic [31:0] pc_in, imem_addr, imem_rdata, if_id_pc, if_id_pc4, if_id_instr;
   int          vectors = 0, miscompares = 0;

   if_id_fetch dut (
      .clock(clock), .resetn(resetn), .pc_in(pc_in), .stall(stall), .flush(flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .pc_en(pc_en), .if_id_valid(if_id_valid),
      .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0001_3570;
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [31:0] p, input logic s, input logic f, input logic rv,
                        input logic [31:0] rd);
      pc_in = p; stall = s; flush = f; imem_rvalid = rv; imem_rdata = rd;
   endtask

   task automatic do_reset;
      resetn = 1'b0;
      drive(32'd100, 0, 0, 0, 0);
      tick;
      resetn = 1'b1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      drive(32'd100, 0, 0, 0, 0);
      tick;
      tick;
      vectors++;
      if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {1'b0, 32'd100, 32'd104, 32'd0}) begin
         miscompares++;
         $display("FAIL reset_ifid: got v=%0b pc=%0d pc4=%0d instr=%h, want v=0 pc=100 pc4=104 instr=0",
                  if_id_valid, if_id_pc, if_id_pc4, if_id_instr);
      end
      vectors++;
      if ({imem_req, pc_en} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_req: got req=%0b pc_en=%0b, want 0 0", imem_req, pc_en);
      end
      resetn = 1'b1;
   endtask

   task automatic test_stream;
      do_reset;
      drive(32'd100, 0, 0, 0, 0);
      #1;
      vectors++;
      if ({imem_req, imem_addr} !== {1'b1, 32'd100}) begin
         miscompares++;
         $display("FAIL stream_first_req: got req=%0b addr=%0d, want 1 100", imem_req, imem_addr);
      end
      tick;
      for (int i = 0; i < 3; i++) begin
         drive(32'd104 + 32'(4 * i), 0, 0, 1, word(32'd100 + 32'(4 * i)));
         #1;
         vectors++;
         if ({imem_req, pc_en} !== 2'b11) begin
            miscompares++;
            $display("FAIL stream_b2b_req[%0d]: got req=%0b pc_en=%0b, want 1 1", i, imem_req, pc_en);
         end
         tick;
         vectors++;
         if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !==
             {1'b1, 32'd100 + 32'(4 * i), 32'd104 + 32'(4 * i), word(32'd100 + 32'(4 * i))}) begin
            miscompares++;
            $display("FAIL stream_ifid[%0d]: got v=%0b pc=%0d pc4=%0d instr=%h, want v=1 pc=%0d pc4=%0d instr=%h",
                     i, if_id_valid, if_id_pc, if_id_pc4, if_id_instr, 100 + 4 * i, 104 + 4 * i,
                     word(32'd100 + 32'(4 * i)));
         end
      end
   endtask

   task automatic test_stall_skid;
      do_reset;
      drive(32'd100, 0, 0, 0, 0);
      tick;
      drive(32'd104, 0, 0, 1, word(32'd100));
      tick;
      drive(32'd108, 1, 0, 1, word(32'd104));
      #1;
      vectors++;
      if (imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL skid_capture_req: got %0b, want 0", imem_req);
      end
      tick;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({if_id_valid, if_id_pc} !== {1'b1, 32'd100}) begin
            miscompares++;
            $display("FAIL skid_hold_ifid[%0d]: got v=%0b pc=%0d, want v=1 pc=100", i, if_id_valid, if_id_pc);
         end
         drive(32'd108, i < 2, 0, 0, 0);
         #1;
         vectors++;
         if (pc_en !== 1'b0) begin
            miscompares++;
            $display("FAIL skid_pc_en[%0d]: got %0b, want 0", i, pc_en);
         end
         tick;
      end
      vectors++;
      if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {1'b1, 32'd104, 32'd108, word(32'd104)}) begin
         miscompares++;
         $display("FAIL skid_release: got v=%0b pc=%0d pc4=%0d instr=%h, want v=1 pc=104 pc4=108 instr=%h",
                  if_id_valid, if_id_pc, if_id_pc4, if_id_instr, word(32'd104));
      end
      drive(32'd108, 0, 0, 0, 0);
      #1;
      vectors++;
      if ({imem_req, imem_addr} !== {1'b1, 32'd108}) begin
         miscompares++;
         $display("FAIL skid_next_req: got req=%0b addr=%0d, want 1 108", imem_req, imem_addr);
      end
      tick;
      vectors++;
      if (if_id_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL skid_no_dup: got valid=%0b, want 0", if_id_valid);
      end
   endtask

   task automatic test_flush_drain;
      do_reset;
      drive(32'd100, 0, 0, 0, 0);
      tick;
      for (int i = 0; i < 3; i++) begin
         drive(32'd200, 0, i == 0, i == 2, word(32'd100));
         #1;
         vectors++;
         if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_req[%0d]: got %0b, want 0", i, imem_req);
         end
         tick;
         vectors++;
         if ({if_id_valid, if_id_instr} !== {1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL drain_ifid[%0d]: got v=%0b instr=%h, want v=0 instr=0", i, if_id_valid, if_id_instr);
         end
      end
      drive(32'd200, 0, 0, 0, 0);
      #1;
      vectors++;
      if ({imem_req, imem_addr} !== {1'b1, 32'd200}) begin
         miscompares++;
         $display("FAIL drain_redirect_req: got req=%0b addr=%0d, want 1 200", imem_req, imem_addr);
      end
      tick;
      drive(32'd204, 0, 0, 1, word(32'd200));
      tick;
      vectors++;
      if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'd200, word(32'd200)}) begin
         miscompares++;
         $display("FAIL drain_redirect_load: got v=%0b pc=%0d instr=%h, want v=1 pc=200 instr=%h",
                  if_id_valid, if_id_pc, if_id_instr, word(32'd200));
      end
   endtask

   task automatic test_flush_stall;
      do_reset;
      drive(32'd100, 0, 0, 0, 0);
      tick;
      drive(32'd104, 0, 0, 1, word(32'd100));
      tick;
      drive(32'd104, 1, 1, 0, 0);
      tick;
      vectors++;
      if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 32'd100, 32'd0}) begin
         miscompares++;
         $display("FAIL flush_beats_stall: got v=%0b pc=%0d instr=%h, want v=0 pc=100 instr=0",
                  if_id_valid, if_id_pc, if_id_instr);
      end
   endtask

   task automatic test_reset_midwait;
      do_reset;
      drive(32'd300, 0, 0, 0, 0);
      tick;
      drive(32'd304, 0, 0, 1, word(32'd300));
      tick;
      resetn = 1'b0;
      drive(32'd304, 0, 0, 0, 0);
      tick;
      vectors++;
      if ({imem_req, pc_en} !== 2'b00) begin
         miscompares++;
         $display("FAIL midwait_req_in_reset: got req=%0b pc_en=%0b, want 0 0", imem_req, pc_en);
      end
      tick;
      resetn = 1'b1;
      drive(32'd304, 1, 0, 1, word(32'd304));
      tick;
      vectors++;
      if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {1'b0, 32'd100, 32'd104, 32'd0}) begin
         miscompares++;
         $display("FAIL midwait_stale_resp: got v=%0b pc=%0d pc4=%0d instr=%h, want v=0 pc=100 pc4=104 instr=0",
                  if_id_valid, if_id_pc, if_id_pc4, if_id_instr);
      end
      drive(32'd304, 0, 0, 0, 0);
      #1;
      vectors++;
      if (imem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL midwait_idle_req: got %0b, want 1", imem_req);
      end
      tick;
   endtask

   task automatic test_wrap;
      do_reset;
      drive(32'hFFFF_FFFC, 0, 0, 0, 0);
      tick;
      drive(32'h0000_0000, 0, 0, 1, 32'hDEAD_BEEF);
      tick;
      vectors++;
      if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'hDEAD_BEEF}) begin
         miscompares++;
         $display("FAIL pc4_wrap: got v=%0b pc=%h pc4=%h instr=%h, want v=1 pc=fffffffc pc4=0 instr=deadbeef",
                  if_id_valid, if_id_pc, if_id_pc4, if_id_instr);
      end
   endtask

   // Model: an outstanding-request flag, a drain flag and a skid queue; memory replies 1..3 cycles later.
   task automatic test_random;
      logic        m_valid, m_out, m_drain, exp_req, st, fl, rv, ld, mem_busy;
      logic [31:0] m_pc, m_pc4, m_instr, m_out_pc, pc, rd, lpc, linstr, mem_addr;
      logic [63:0] m_skid[$];
      int          mem_wait;
      do_reset;
      m_valid = 0; m_pc = 100; m_pc4 = 104; m_instr = 0; m_out = 0; m_drain = 0;
      mem_busy = 0; mem_wait = 0; mem_addr = 0; m_out_pc = 0; pc = 32'd100;
      m_skid.delete();
      for (int c = 0; c < 400; c++) begin
         st = ($urandom % 10) < 3;
         fl = ($urandom % 12) == 0;
         pc = ($urandom % 5 == 0) ? {$urandom, 2'b00} >> 2 << 2 : pc + 32'd4;
         rv = mem_busy && mem_wait == 0;
         rd = rv ? word(mem_addr) : $urandom;
         drive(pc, st, fl, rv, rd);
         #1;
         exp_req = (m_skid.size() == 0) && !st && !fl && (!m_out || (rv && !m_drain));
         vectors++;
         if ({imem_req, pc_en, imem_addr} !== {exp_req, exp_req, pc}) begin
            miscompares++;
            $display("FAIL rand_req[%0d]: got req=%0b pc_en=%0b addr=%h, want req=%0b pc_en=%0b addr=%h",
                     c, imem_req, pc_en, imem_addr, exp_req, exp_req, pc);
         end
         ld = 0; lpc = 0; linstr = 0;
         if (m_drain) begin
            if (rv) begin m_out = 0; m_drain = 0; end
         end else if (fl) begin
            if (m_out && rv) m_out = 0;
            else if (m_out) m_drain = 1;
            m_skid.delete();
         end else if (m_skid.size() > 0) begin
            if (!st) begin ld = 1; {lpc, linstr} = m_skid.pop_front(); end
         end else if (m_out && rv) begin
            m_out = 0;
            if (st) m_skid.push_back({m_out_pc, rd});
            else begin ld = 1; lpc = m_out_pc; linstr = rd; end
         end
         if (exp_req) begin m_out = 1; m_out_pc = pc; end
         if (fl) begin
            m_valid = 0; m_instr = 0;
         end else if (!st) begin
            m_valid = ld;
            m_instr = ld ? linstr : 32'd0;
            if (ld) begin m_pc = lpc; m_pc4 = lpc + 32'd4; end
         end
         if (rv) mem_busy = 0;
         else if (mem_busy) mem_wait--;
         if (exp_req) begin mem_busy = 1; mem_wait = $urandom_range(0, 2); mem_addr = pc; end
         tick;
         vectors++;
         if ({if_id_valid, if_id_pc, if_id_pc4, if_id_instr} !== {m_valid, m_pc, m_pc4, m_instr}) begin
            miscompares++;
            $display("FAIL rand_ifid[%0d]: got v=%0b pc=%h pc4=%h instr=%h, want v=%0b pc=%h pc4=%h instr=%h",
                     c, if_id_valid, if_id_pc, if_id_pc4, if_id_instr, m_valid, m_pc, m_pc4, m_instr);
         end
      end
   endtask

   initial begin
      resetn = 1'b0;
      drive(32'd100, 0, 0, 0, 0);
      test_reset;
      test_stream;
      test_stall_skid;
      test_flush_drain;
      test_flush_stall;
      test_reset_midwait;
      test_wrap;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
